// File: rtl/ctrl_pkg.sv
// Purpose : shared encodings for the multi-cycle instruction controller (opcodes, states, field codes, ies_ctl layout).
// Latency : n/a (constants and pure functions only).
// Backpressure: n/a.
// Ports   : none. Optional feature macro used by the importers: CTRL_FSM_ILLEGAL_TRAP_EN.
package ctrl_pkg;

   // Opcodes, IR[15:12]; 4'hB..4'hE are unassigned.
   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_LI   = 4'h4;
   localparam logic [3:0] OP_BEQ  = 4'h5;
   localparam logic [3:0] OP_BNE  = 4'h6;
   localparam logic [3:0] OP_JAL  = 4'h7;
   localparam logic [3:0] OP_RET  = 4'h8;
   localparam logic [3:0] OP_IN   = 4'h9;
   localparam logic [3:0] OP_OUT  = 4'hA;
   localparam logic [3:0] OP_HALT = 4'hF;

   // Controller states.
   localparam logic [2:0] ST_FETCH     = 3'd0;
   localparam logic [2:0] ST_DECODE    = 3'd1;
   localparam logic [2:0] ST_FETCH_IMM = 3'd2;
   localparam logic [2:0] ST_EXEC      = 3'd3;
   localparam logic [2:0] ST_WB        = 3'd4;
   localparam logic [2:0] ST_BRANCH    = 3'd5;
   localparam logic [2:0] ST_IO_WAIT   = 3'd6;
   localparam logic [2:0] ST_HALT      = 3'd7;

   // ALU operation codes.
   localparam logic [2:0] ALU_AND = 3'd0;
   localparam logic [2:0] ALU_OR  = 3'd1;
   localparam logic [2:0] ALU_ADD = 3'd2;
   localparam logic [2:0] ALU_SUB = 3'd3;

   // Register write-back source select.
   localparam logic [1:0] RS_IMM = 2'd0;
   localparam logic [1:0] RS_IO  = 2'd1;
   localparam logic [1:0] RS_ALU = 2'd2;

   // PC source select.
   localparam logic [1:0] PC_INC = 2'd0;
   localparam logic [1:0] PC_RA  = 2'd1;
   localparam logic [1:0] PC_IMM = 2'd2;

   // Bit positions of the fields inside the 15-bit ies_ctl word.
   localparam int IES_W          = 15;
   localparam int IES_BACKUP     = 14;
   localparam int IES_RESTORE    = 13;
   localparam int IES_WRITE_CR   = 12;
   localparam int IES_REGSRC_MSB = 11;
   localparam int IES_REGSRC_LSB = 10;
   localparam int IES_CMPEQ      = 9;
   localparam int IES_CMPNE      = 8;
   localparam int IES_REG_R1     = 7;
   localparam int IES_REG_R2     = 6;
   localparam int IES_REG_W1     = 5;
   localparam int IES_REG_W2     = 4;
   localparam int IES_ALU_SRC    = 3;
   localparam int IES_ALUOP_MSB  = 2;
   localparam int IES_ALUOP_LSB  = 0;

   // Field order, MSB first, matches the positions above.
   typedef struct packed {
      logic       backup;
      logic       restore;
      logic       write_cr;
      logic [1:0] regsrc;
      logic       cmpeq;
      logic       cmpne;
      logic       reg_r1;
      logic       reg_r2;
      logic       reg_w1;
      logic       reg_w2;
      logic       alu_src;
      logic [2:0] alu_op;
   } ies_ctl_t;

   // Instructions that carry a trailing immediate word.
   function automatic logic needs_imm(input logic [3:0] op);
      return (op == OP_LI) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_JAL);
   endfunction

   function automatic logic is_illegal(input logic [3:0] op);
      return (op >= 4'hB) && (op <= 4'hE);
   endfunction

endpackage

// File: rtl/ctrl_fsm_if.sv
// Purpose : bundle between the controller (master) and the execution system / I/O port (slave).
// Latency : n/a (wires only).
// Backpressure: io_req is held by the master until the slave raises io_ack.
// Ports   : op, cmp_result, io_ack toward master; ies_ctl, PCwrite, PCsrc, IRwrite, ImRwrite,
//           io_req, halted (and illegal when CTRL_FSM_ILLEGAL_TRAP_EN is defined) toward slave.
interface ctrl_fsm_if;
   logic [3:0]  op;
   logic        cmp_result;
   logic        io_ack;
   logic [14:0] ies_ctl;
   logic        PCwrite;
   logic [1:0]  PCsrc;
   logic        IRwrite;
   logic        ImRwrite;
   logic        io_req;
   logic        halted;
`ifdef CTRL_FSM_ILLEGAL_TRAP_EN
   logic        illegal;
`endif

   modport master (
      input  op, cmp_result, io_ack,
      output ies_ctl, PCwrite, PCsrc, IRwrite, ImRwrite, io_req, halted
`ifdef CTRL_FSM_ILLEGAL_TRAP_EN
      , output illegal
`endif
   );

   modport slave (
      output op, cmp_result, io_ack,
      input  ies_ctl, PCwrite, PCsrc, IRwrite, ImRwrite, io_req, halted
`ifdef CTRL_FSM_ILLEGAL_TRAP_EN
      , input illegal
`endif
   );
endinterface

// File: rtl/ctrl_decode.sv
// Purpose : combinational output decode of the controller state (Moore, plus the IO_WAIT ack strobe).
// Latency : 0 cycles, purely combinational.
// Backpressure: none; io_ack only shapes the IN write-back strobe while in IO_WAIT.
// Ports   : state_i, op_i, cmp_result_i, io_ack_i in; ies_ctl_o, pc_write_o, pc_src_o, ir_write_o,
//           imr_write_o, io_req_o, halted_o out.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [2:0]  state_i,
   input  logic [3:0]  op_i,
   input  logic        cmp_result_i,
   input  logic        io_ack_i,
   output logic [14:0] ies_ctl_o,
   output logic        pc_write_o,
   output logic [1:0]  pc_src_o,
   output logic        ir_write_o,
   output logic        imr_write_o,
   output logic        io_req_o,
   output logic        halted_o
);

   ies_ctl_t ctl;

   always_comb begin
      ctl         = '0;
      pc_write_o  = 1'b0;
      pc_src_o    = PC_INC;
      ir_write_o  = 1'b0;
      imr_write_o = 1'b0;
      io_req_o    = 1'b0;
      halted_o    = 1'b0;
      case (state_i)
         ST_FETCH: begin
            ir_write_o = 1'b1;
            pc_write_o = 1'b1;
         end
         ST_DECODE: begin
            ctl.reg_r1 = 1'b1;
            ctl.reg_r2 = 1'b1;
         end
         ST_FETCH_IMM: begin
            imr_write_o = 1'b1;
            pc_write_o  = 1'b1;
         end
         ST_EXEC: begin
            case (op_i)
               OP_ADD: begin ctl.alu_src = 1'b1; ctl.alu_op = ALU_ADD; end
               OP_SUB: begin ctl.alu_src = 1'b1; ctl.alu_op = ALU_SUB; end
               OP_AND: begin ctl.alu_src = 1'b1; ctl.alu_op = ALU_AND; end
               OP_OR:  begin ctl.alu_src = 1'b1; ctl.alu_op = ALU_OR;  end
               OP_LI: begin
                  ctl.regsrc = RS_IMM;
                  ctl.reg_w2 = 1'b1;
               end
               OP_BEQ: begin
                  ctl.cmpeq    = 1'b1;
                  ctl.write_cr = 1'b1;
               end
               OP_BNE: begin
                  ctl.cmpne    = 1'b1;
                  ctl.write_cr = 1'b1;
               end
               OP_JAL: begin
                  ctl.backup = 1'b1;
                  pc_write_o = 1'b1;
                  pc_src_o   = PC_IMM;
               end
               OP_RET: begin
                  ctl.restore = 1'b1;
                  pc_write_o  = 1'b1;
                  pc_src_o    = PC_RA;
               end
               OP_IN, OP_OUT: io_req_o = 1'b1;
               default: ;
            endcase
         end
         ST_WB: begin
            ctl.regsrc = RS_ALU;
            ctl.reg_w2 = 1'b1;
         end
         ST_BRANCH: begin
            // The compare flag is only meaningful here, after EXEC latched it.
            pc_write_o = cmp_result_i;
            pc_src_o   = PC_IMM;
         end
         ST_IO_WAIT: begin
            io_req_o = 1'b1;
            // IN captures the port data in the same cycle the port acknowledges.
            if (io_ack_i && (op_i == OP_IN)) begin
               ctl.regsrc = RS_IO;
               ctl.reg_w2 = 1'b1;
            end
         end
         ST_HALT: halted_o = 1'b1;
         default: ;
      endcase
   end

   assign ies_ctl_o = ctl;

endmodule

// File: rtl/ctrl_fsm.sv
// Purpose : multi-cycle instruction sequencer driving the execution system and the I/O handshake.
// Latency : 2..5 cycles per instruction (IN/OUT unbounded, waiting on io_ack); HALT until reset.
// Backpressure: IO_WAIT stalls with io_req held high until io_ack.
// Ports   : clk, reset (sync, active-high); bus (ctrl_fsm_if.master): op, cmp_result, io_ack in;
//           ies_ctl, PCwrite, PCsrc, IRwrite, ImRwrite, io_req, halted out.
//           CTRL_FSM_ILLEGAL_TRAP_EN defined: illegal opcodes trap to HALT and bus.illegal is present;
//           undefined: illegal opcodes retire as a 2-cycle NOP.
module ctrl_fsm
   import ctrl_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   ctrl_fsm_if.master bus
);

   logic [2:0]  state_q, state_d;
   // Set while reset is applied: parks the FSM in FETCH with every output forced low,
   // so the first real FETCH lands in the cycle right after reset is released.
   logic        hold_q;

   logic [14:0] dec_ies;
   logic        dec_pc_write;
   logic [1:0]  dec_pc_src;
   logic        dec_ir_write;
   logic        dec_imr_write;
   logic        dec_io_req;
   logic        dec_halted;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH: state_d = ST_DECODE;
         ST_DECODE: begin
            if (needs_imm(bus.op)) begin
               state_d = ST_FETCH_IMM;
            end else if (is_illegal(bus.op)) begin
`ifdef CTRL_FSM_ILLEGAL_TRAP_EN
               state_d = ST_HALT;
`else
               state_d = ST_FETCH;
`endif
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_FETCH_IMM: state_d = ST_EXEC;
         ST_EXEC: begin
            case (bus.op)
               OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = ST_WB;
               OP_BEQ, OP_BNE:                state_d = ST_BRANCH;
               OP_IN, OP_OUT:                 state_d = ST_IO_WAIT;
               OP_HALT:                       state_d = ST_HALT;
               default:                       state_d = ST_FETCH;
            endcase
         end
         ST_WB:      state_d = ST_FETCH;
         ST_BRANCH:  state_d = ST_FETCH;
         ST_IO_WAIT: state_d = bus.io_ack ? ST_FETCH : ST_IO_WAIT;
         ST_HALT:    state_d = ST_HALT;
         default:    state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_FETCH;
         hold_q  <= 1'b1;
      end else if (hold_q) begin
         hold_q  <= 1'b0;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef CTRL_FSM_ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;

   // Sticky trap flag, raised on the same edge that enters HALT from DECODE.
   assign illegal_d = illegal_q ||
                      (!hold_q && (state_q == ST_DECODE) && is_illegal(bus.op));

   always_ff @(posedge clk) begin
      if (reset) begin
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= illegal_d;
      end
   end

   assign bus.illegal = illegal_q;
`endif

   ctrl_decode u_decode (
      .state_i      (state_q),
      .op_i         (bus.op),
      .cmp_result_i (bus.cmp_result),
      .io_ack_i     (bus.io_ack),
      .ies_ctl_o    (dec_ies),
      .pc_write_o   (dec_pc_write),
      .pc_src_o     (dec_pc_src),
      .ir_write_o   (dec_ir_write),
      .imr_write_o  (dec_imr_write),
      .io_req_o     (dec_io_req),
      .halted_o     (dec_halted)
   );

   assign bus.ies_ctl  = hold_q ? '0   : dec_ies;
   assign bus.PCwrite  = hold_q ? 1'b0 : dec_pc_write;
   assign bus.PCsrc    = hold_q ? 2'd0 : dec_pc_src;
   assign bus.IRwrite  = hold_q ? 1'b0 : dec_ir_write;
   assign bus.ImRwrite = hold_q ? 1'b0 : dec_imr_write;
   assign bus.io_req   = hold_q ? 1'b0 : dec_io_req;
   assign bus.halted   = hold_q ? 1'b0 : dec_halted;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Purpose : directed self-checking bench for ctrl_fsm.
// Latency : inputs change on the falling edge; outputs are sampled 1 time unit later.
// Backpressure: io_ack driven per cycle from the stimulus tables.
module tb_ctrl_fsm;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   ctrl_fsm_if bus ();

   ctrl_fsm dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed vector: {ies_ctl[14:0], PCwrite, PCsrc[1:0], IRwrite, ImRwrite, io_req, halted}
   // ies_ctl bits: 14 backup, 13 restore, 12 writeCR, 11:10 Regsrc, 9 cmpeq, 8 cmpne,
   //               7 RegR1, 6 RegR2, 5 RegW1, 4 RegW2, 3 ALUsrc, 2:0 ALUop.
   localparam logic [21:0] V_ZERO   = 22'h0;
   localparam logic [21:0] V_FETCH  = {15'h0000, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam logic [21:0] V_DECODE = {15'h00C0, 7'b0};
   localparam logic [21:0] V_FIMM   = {15'h0000, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam logic [21:0] V_ADD    = {15'h000A, 7'b0};
   localparam logic [21:0] V_SUB    = {15'h000B, 7'b0};
   localparam logic [21:0] V_AND    = {15'h0008, 7'b0};
   localparam logic [21:0] V_OR     = {15'h0009, 7'b0};
   localparam logic [21:0] V_WB     = {15'h0810, 7'b0};
   localparam logic [21:0] V_LI     = {15'h0010, 7'b0};
   localparam logic [21:0] V_BEQ    = {15'h1200, 7'b0};
   localparam logic [21:0] V_BNE    = {15'h1100, 7'b0};
   localparam logic [21:0] V_BR_T   = {15'h0000, 1'b1, 2'd2, 4'b0};
   localparam logic [21:0] V_BR_N   = {15'h0000, 1'b0, 2'd2, 4'b0};
   localparam logic [21:0] V_JAL    = {15'h4000, 1'b1, 2'd2, 4'b0};
   localparam logic [21:0] V_RET    = {15'h2000, 1'b1, 2'd1, 4'b0};
   localparam logic [21:0] V_IOREQ  = {15'h0000, 7'b0000010};
   localparam logic [21:0] V_INACK  = {15'h0410, 7'b0000010};
   localparam logic [21:0] V_HALT   = {15'h0000, 7'b0000001};

   function automatic logic [21:0] obs();
      return {bus.ies_ctl, bus.PCwrite, bus.PCsrc, bus.IRwrite, bus.ImRwrite, bus.io_req, bus.halted};
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      bus.op = 4'h0;
      bus.cmp_result = 1'b0;
      bus.io_ack = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (obs() !== V_ZERO) begin
         errors++;
         $display("FAIL reset_outputs got %h expected %h", obs(), V_ZERO);
      end
`ifdef CTRL_FSM_ILLEGAL_TRAP_EN
      checks++;
      if (bus.illegal !== 1'b0) begin
         errors++;
         $display("FAIL reset_illegal got %b expected 0", bus.illegal);
      end
`endif
      reset = 1'b0;
   endtask

   task automatic test_alu();
      logic [3:0]  ops  [4] = '{4'h0, 4'h1, 4'h2, 4'h3};
      logic [21:0] exec [4] = '{V_ADD, V_SUB, V_AND, V_OR};
      logic [21:0] exp  [4];
      for (int k = 0; k < 4; k++) begin
         exp = '{V_FETCH, V_DECODE, exec[k], V_WB};
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) bus.op = ops[k];
            #1;
            checks++;
            if (obs() !== exp[i]) begin
               errors++;
               $display("FAIL alu_op%0d_cycle%0d got %h expected %h", ops[k], i + 1, obs(), exp[i]);
            end
         end
      end
   endtask

   task automatic test_li();
      logic [21:0] exp [4] = '{V_FETCH, V_DECODE, V_FIMM, V_LI};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) bus.op = 4'h4;
         #1;
         checks++;
         if (obs() !== exp[i]) begin
            errors++;
            $display("FAIL li_cycle%0d got %h expected %h", i + 1, obs(), exp[i]);
         end
      end
   endtask

   task automatic test_branch();
      logic [3:0]  ops [3] = '{4'h5, 4'h5, 4'h6};
      logic        cmp [3] = '{1'b1, 1'b0, 1'b1};
      logic [21:0] ex  [3] = '{V_BEQ, V_BEQ, V_BNE};
      logic [21:0] br  [3] = '{V_BR_T, V_BR_N, V_BR_T};
      logic [21:0] exp [5];
      for (int k = 0; k < 3; k++) begin
         exp = '{V_FETCH, V_DECODE, V_FIMM, ex[k], br[k]};
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) bus.op = ops[k];
            // cmp_result is held at the opposite value until BRANCH to show it is ignored earlier
            bus.cmp_result = (i == 4) ? cmp[k] : ~cmp[k];
            #1;
            checks++;
            if (obs() !== exp[i]) begin
               errors++;
               $display("FAIL branch%0d_cycle%0d got %h expected %h", k, i + 1, obs(), exp[i]);
            end
         end
      end
      bus.cmp_result = 1'b0;
   endtask

   task automatic test_jal_ret();
      logic [3:0]  ops [7] = '{4'h7, 4'h7, 4'h7, 4'h7, 4'h8, 4'h8, 4'h8};
      logic [21:0] exp [7] = '{V_FETCH, V_DECODE, V_FIMM, V_JAL, V_FETCH, V_DECODE, V_RET};
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         bus.op = ops[i];
         #1;
         checks++;
         if (obs() !== exp[i]) begin
            errors++;
            $display("FAIL jal_ret_cycle%0d got %h expected %h", i + 1, obs(), exp[i]);
         end
      end
   endtask

   task automatic test_io();
      // IN: ack low through EXEC and two waits, high on the third wait cycle
      // OUT: ack pulsed during EXEC (ignored), then acknowledged on the second wait cycle
      logic [3:0]  ops [11] = '{4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9,
                                4'hA, 4'hA, 4'hA, 4'hA, 4'hA};
      logic        ack [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [21:0] exp [11] = '{V_FETCH, V_DECODE, V_IOREQ, V_IOREQ, V_IOREQ, V_INACK,
                                V_FETCH, V_DECODE, V_IOREQ, V_IOREQ, V_IOREQ};
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         bus.op = ops[i];
         bus.io_ack = ack[i];
         #1;
         checks++;
         if (obs() !== exp[i]) begin
            errors++;
            $display("FAIL io_cycle%0d got %h expected %h", i + 1, obs(), exp[i]);
         end
      end
      @(negedge clk);
      bus.io_ack = 1'b0;
      #1;
      checks++;
      if (obs() !== V_FETCH) begin
         errors++;
         $display("FAIL io_return_fetch got %h expected %h", obs(), V_FETCH);
      end
   endtask

   task automatic test_reset_in_io_wait();
      // Already in FETCH (from test_io); walk IN into IO_WAIT, then reset there.
      bus.op = 4'h9;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (obs() !== V_IOREQ) begin
         errors++;
         $display("FAIL rst_io_wait_entry got %h expected %h", obs(), V_IOREQ);
      end
      reset = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (obs() !== V_ZERO) begin
         errors++;
         $display("FAIL rst_io_wait_drop got %h expected %h", obs(), V_ZERO);
      end
      reset = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (obs() !== V_FETCH) begin
         errors++;
         $display("FAIL rst_io_wait_fetch got %h expected %h", obs(), V_FETCH);
      end
   endtask

   task automatic test_illegal();
      bus.op = 4'hB;
      @(negedge clk);
      #1;
      checks++;
      if (obs() !== V_DECODE) begin
         errors++;
         $display("FAIL illegal_decode got %h expected %h", obs(), V_DECODE);
      end
`ifdef CTRL_FSM_ILLEGAL_TRAP_EN
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (obs() !== V_HALT || bus.illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_trap_cycle%0d got %h/%b expected %h/1", i, obs(), bus.illegal, V_HALT);
         end
      end
      reset = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (obs() !== V_ZERO || bus.illegal !== 1'b0) begin
         errors++;
         $display("FAIL illegal_clear got %h/%b expected %h/0", obs(), bus.illegal, V_ZERO);
      end
      reset = 1'b0;
`endif
      @(negedge clk);
      #1;
      checks++;
      if (obs() !== V_FETCH) begin
         errors++;
         $display("FAIL illegal_next_fetch got %h expected %h", obs(), V_FETCH);
      end
   endtask

   task automatic test_halt();
      bus.op = 4'hF;
      @(negedge clk);
      #1;
      checks++;
      if (obs() !== V_DECODE) begin
         errors++;
         $display("FAIL halt_decode got %h expected %h", obs(), V_DECODE);
      end
      @(negedge clk);
      #1;
      checks++;
      if (obs() !== V_ZERO) begin
         errors++;
         $display("FAIL halt_exec got %h expected %h", obs(), V_ZERO);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.io_ack = i[0];
         bus.cmp_result = ~i[0];
         bus.op = 4'h0;
         #1;
         checks++;
         if (obs() !== V_HALT) begin
            errors++;
            $display("FAIL halt_hold_cycle%0d got %h expected %h", i, obs(), V_HALT);
         end
      end
      bus.io_ack = 1'b0;
      bus.cmp_result = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (obs() !== V_ZERO) begin
         errors++;
         $display("FAIL halt_reset got %h expected %h", obs(), V_ZERO);
      end
      reset = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (obs() !== V_FETCH) begin
         errors++;
         $display("FAIL halt_reset_fetch got %h expected %h", obs(), V_FETCH);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_alu();
      test_li();
      test_branch();
      test_jal_ret();
      test_io();
      test_reset_in_io_wait();
      test_illegal();
      test_halt();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
